// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared shift-add multiplier controller.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    // Requester ID width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
// Latency: zero cycles.
// Backpressure: none; pure function of its inputs.
module mult_rr_pick
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int j;

    // Scan from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[j]) begin
                idx = IW'(j);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential signed shift-add multiplier among NUM_REQ requesters.
// Latency: rsp_valid rises 2*WIDTH edges after the accept edge.
// Backpressure: product held in DONE until rsp_ready; no grants meanwhile.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int IW      = id_width(NUM_REQ),
    localparam int PW      = 2 * WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PW-1:0]            rsp_p,
    output logic [IW-1:0]            rsp_id,
    output logic                     busy
);

    localparam int CW = $clog2(PW);

    state_t               state, state_nxt;
    logic [PW-1:0]        mcand, mplier, acc, acc_nxt;
    logic [CW-1:0]        ctr;
    logic [IW-1:0]        rr_ptr, id, pick_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 pick_any;
    logic                 accept, last, rsp_done;
    logic [WIDTH-1:0]     sel_a, sel_b;

    mult_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_a    = req_a[pick_idx*WIDTH +: WIDTH];
    assign sel_b    = req_b[pick_idx*WIDTH +: WIDTH];
    assign accept   = (state == IDLE) && pick_any;
    assign last     = (state == RUN) && (ctr == CW'(PW - 1));
    assign rsp_done = (state == DONE) && rsp_valid && rsp_ready;
    // The multiplier is sign-extended too, so the upper bits carry the sign weight.
    assign acc_nxt  = mplier[ctr] ? (acc + (mcand << ctr)) : acc;
    assign rsp_id   = id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        req_ready = (state == IDLE) ? grant : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            ctr       <= '0;
            id        <= '0;
            rr_ptr    <= '0;
            rsp_p     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                mcand  <= {{WIDTH{sel_a[WIDTH-1]}}, sel_a};
                mplier <= {{WIDTH{sel_b[WIDTH-1]}}, sel_b};
                acc    <= '0;
                ctr    <= '0;
                id     <= pick_idx;
            end
            if (state == RUN) begin
                acc <= acc_nxt;
                ctr <= ctr + CW'(1);
                if (last) begin
                    rsp_p     <= acc_nxt;
                    rsp_valid <= 1'b1;
                end
            end
            // Pointer moves only on completion so a stalled consumer skips nobody.
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (id == IW'(NUM_REQ - 1)) ? '0 : id + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with NUM_REQ=4, WIDTH=8.
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_p;
    logic [1:0]  rsp_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mult_share_ctrl #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    // Wait for a grant, check it, step past the accept edge.
    task automatic wait_grant(input string tag, input int exp_id, input bit drop);
        int n;
        logic [3:0] exp_g;
        n = 0;
        exp_g = 4'b0001 << exp_id;
        #1;
        while (!(|req_ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_grant"}, {28'd0, req_ready}, {28'd0, exp_g});
        @(posedge clk);
        #1;
        if (drop) begin
            req_valid[exp_id] = 1'b0;
            set_op(exp_id, 8'hA5, 8'h5A);
        end
    endtask

    task automatic wait_rsp(input string tag, input int exp_id, input logic [15:0] exp_p);
        int edges;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!rsp_valid && edges < 40);
        chk({tag, "_lat"}, edges, 16);
        chk({tag, "_p"}, {16'd0, rsp_p}, {16'd0, exp_p});
        chk({tag, "_id"}, {30'd0, rsp_id}, exp_id);
        chk({tag, "_busy"}, {31'd0, busy}, 1);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld_clr"}, {31'd0, rsp_valid}, 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0)
            chk("onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    logic [7:0]  ca [5] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h00};
    logic [7:0]  cb [5] = '{8'h80, 8'hFF, 8'h01, 8'h80, 8'h5A};
    logic [15:0] cp [5] = '{16'h4000, 16'h0001, 16'hFFFF, 16'hC080, 16'h0000};
    logic [7:0]  oa [4] = '{8'h02, 8'hFC, 8'h7F, 8'h80};
    logic [7:0]  ob [4] = '{8'h03, 8'h05, 8'h7F, 8'h01};
    logic [15:0] op [4] = '{16'h0006, 16'hFFEC, 16'h3F01, 16'hFF80};

    initial begin
        int seen;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_vld", {31'd0, rsp_valid}, 0);
        chk("rst_p", {16'd0, rsp_p}, 0);
        chk("rst_id", {30'd0, rsp_id}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;

        // Basic multiply
        set_op(0, 8'd3, 8'd5);
        req_valid[0] = 1'b1;
        wait_grant("t1", 0, 1);
        chk("t1_busy_run", {31'd0, busy}, 1);
        wait_rsp("t1", 0, 16'h000F);
        finish_rsp("t1");

        // Signed corners
        for (int i = 0; i < 5; i++) begin
            set_op(1, ca[i], cb[i]);
            req_valid[1] = 1'b1;
            wait_grant("corner", 1, 1);
            wait_rsp("corner", 1, cp[i]);
            finish_rsp("corner");
        end

        // Round-robin order with all requesters held valid from reset
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, oa[i], ob[i]);
        req_valid = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_grant("order", k % 4, 0);
            wait_rsp("order", k % 4, op[k % 4]);
            finish_rsp("order");
        end
        req_valid = '0;

        // Backpressure on requester 2, requester 1 waiting
        set_op(2, 8'd6, 8'd7);
        req_valid[2] = 1'b1;
        rsp_ready = 1'b0;
        wait_grant("bp", 2, 1);
        wait_rsp("bp", 2, 16'h002A);
        set_op(1, 8'h02, 8'hFD);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld", {31'd0, rsp_valid}, 1);
            chk("bp_p", {16'd0, rsp_p}, 32'h002A);
            chk("bp_id", {30'd0, rsp_id}, 2);
            chk("bp_rdy", {28'd0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_done", {31'd0, rsp_valid}, 0);
        #1;
        chk("bp_next", {28'd0, req_ready}, 32'h2);
        wait_grant("wrap1", 1, 1);
        wait_rsp("wrap1", 1, 16'hFFFA);
        finish_rsp("wrap1");

        // rr_ptr=2: requester 3 beats requester 0
        set_op(0, 8'hF0, 8'h10);
        set_op(3, 8'd5, 8'd5);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_grant("wrap2", 3, 1);
        wait_rsp("wrap2", 3, 16'h0019);
        finish_rsp("wrap2");
        wait_grant("wrap3", 0, 1);
        wait_rsp("wrap3", 0, 16'hFF00);
        finish_rsp("wrap3");

        // Reset with ctr=7 in RUN
        set_op(3, 8'd3, 8'd3);
        req_valid[3] = 1'b1;
        wait_grant("rst_run", 3, 1);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {28'd0, req_ready}, 0);
        chk("midrst_vld", {31'd0, rsp_valid}, 0);
        chk("midrst_p", {16'd0, rsp_p}, 0);
        chk("midrst_id", {30'd0, rsp_id}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        set_op(2, 8'hF6, 8'h07);
        req_valid[2] = 1'b1;
        wait_grant("post", 2, 1);
        wait_rsp("post", 2, 16'hFFBA);
        finish_rsp("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
